// File: rtl/ide_pkg.sv
// Shared definitions for the IDE-over-SPI link: FSM states, header decode bits,
// payload sizes and write-address region selectors.
package ide_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_SECTOR,
    ST_CMD,
    ST_DISCARD
  } ide_state_e;

  localparam int HDR_SECTOR = 7;
  localparam int HDR_CMD    = 6;

  localparam int DEF_SECTOR_WORDS = 256;
  localparam int DEF_CMD_WORDS    = 4;

  localparam logic REGION_SECTOR = 1'b0;
  localparam logic REGION_CMD    = 1'b1;

  function automatic logic [15:0] byte_swap(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/ide_sync.sv
// N-stage single-bit synchronizer with a configurable reset value.
module ide_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_q[gi] <= rst_val;
          else        sync_q[gi] <= d;
        end
      end else begin : g_next
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) sync_q[gi] <= rst_val;
          else        sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/ide_spi_link.sv
// SPI slave bridging an MCU to IDE sector/command-file storage: frames carry a
// header byte and 16-bit words, while sector RAM words stream back on MISO.
module ide_spi_link
  import ide_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int SECTOR_WORDS = DEF_SECTOR_WORDS,
  parameter int CMD_WORDS    = DEF_CMD_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_ss_n,
  input  logic        spi_sclk,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  output logic        wr_valid,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_req,
  output logic [7:0]  rd_addr,
  input  logic [15:0] rd_data,
  output logic        frame_done,
  output logic        frame_abort
);

  localparam logic [7:0] SECTOR_LAST = 8'(SECTOR_WORDS - 1);
  localparam logic [7:0] CMD_LAST    = 8'(CMD_WORDS - 1);

  logic ss_s, sclk_s, mosi_s;

  ide_sync #(.STAGES(SYNC_STAGES)) u_sync_ss (
    .clk(clk), .reset(reset), .rst_val(1'b1), .d(spi_ss_n), .q(ss_s)
  );
  ide_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
    .clk(clk), .reset(reset), .rst_val(1'b0), .d(spi_sclk), .q(sclk_s)
  );
  ide_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .reset(reset), .rst_val(1'b0), .d(spi_mosi), .q(mosi_s)
  );

  // Frame edges are honoured only once the synchronizers hold real samples and
  // select has been seen high, so a frame interrupted by reset is ignored.
  logic [7:0] flush_cnt_q;
  logic       armed_q, ss_prev_q, sclk_prev_q;
  logic       flushed;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;

  assign flushed   = (flush_cnt_q == 8'(SYNC_STAGES));
  assign ss_fall   = armed_q & ss_prev_q & ~ss_s;
  assign ss_rise   = armed_q & ~ss_prev_q & ss_s;
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_cnt_q <= '0;
      armed_q     <= 1'b0;
      ss_prev_q   <= 1'b1;
      sclk_prev_q <= 1'b0;
    end else begin
      if (!flushed) flush_cnt_q <= flush_cnt_q + 8'd1;
      armed_q     <= armed_q | (flushed & ss_s);
      ss_prev_q   <= ss_s;
      sclk_prev_q <= sclk_s;
    end
  end

  ide_state_e  state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  word_cnt_q, word_cnt_d;
  logic [15:0] shin_q, shin_d;
  logic [15:0] rx_word;
  logic        wr_valid_q, wr_valid_d;
  logic [8:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic        frame_abort_q, frame_abort_d;
  logic        in_word_state, word_done;

  assign rx_word       = {shin_q[14:0], mosi_s};
  assign in_word_state = (state_q == ST_SECTOR) || (state_q == ST_CMD);
  assign word_done     = sclk_rise && !ss_rise && in_word_state && (bit_cnt_q == 4'd15);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      shin_q        <= '0;
      wr_valid_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      shin_q        <= shin_d;
      wr_valid_q    <= wr_valid_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    shin_d     = shin_q;
    unique case (state_q)
      ST_IDLE: begin
        if (ss_fall) begin
          state_d    = ST_HEADER;
          bit_cnt_d  = '0;
          word_cnt_d = '0;
          shin_d     = '0;
        end
      end
      ST_HEADER: begin
        if (sclk_rise) begin
          shin_d    = rx_word;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (rx_word[HDR_SECTOR])   state_d = ST_SECTOR;
            else if (rx_word[HDR_CMD]) state_d = ST_CMD;
            else                       state_d = ST_DISCARD;
          end
        end
      end
      ST_SECTOR, ST_CMD: begin
        if (sclk_rise) begin
          shin_d    = rx_word;
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            word_cnt_d = word_cnt_q + 8'd1;
            if (state_q == ST_SECTOR && word_cnt_q == SECTOR_LAST) begin
              state_d    = ST_CMD;
              word_cnt_d = '0;
            end else if (state_q == ST_CMD && word_cnt_q == CMD_LAST) begin
              state_d = ST_DISCARD;
            end
          end
        end
      end
      ST_DISCARD: ;
      default: state_d = ST_IDLE;
    endcase
    if (ss_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end
  end

  always_comb begin
    wr_valid_d    = word_done;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = word_done && (state_q == ST_CMD) && (word_cnt_q == CMD_LAST);
    frame_abort_d = ss_rise && (bit_cnt_q != 4'd0) &&
                    ((state_q == ST_HEADER) || in_word_state);
    if (word_done) begin
      wr_addr_d = {(state_q == ST_CMD) ? REGION_CMD : REGION_SECTOR, word_cnt_q};
      wr_data_d = (state_q == ST_SECTOR) ? byte_swap(rx_word) : rx_word;
    end
  end

  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;

  // Read path: the next word is fetched at the 16th rising edge into a buffer
  // and swapped into the shift register on the following falling edge.
  logic        rd_active_q, rd_req_q, rd_load_q, rd_first_q, rd_swap_q;
  logic [7:0]  rd_addr_q;
  logic [3:0]  rd_bit_cnt_q;
  logic [15:0] rd_buf_q, miso_sr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_active_q  <= 1'b0;
      rd_req_q     <= 1'b0;
      rd_load_q    <= 1'b0;
      rd_first_q   <= 1'b0;
      rd_swap_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_bit_cnt_q <= '0;
      rd_buf_q     <= '0;
      miso_sr_q    <= '0;
    end else begin
      rd_req_q  <= 1'b0;
      rd_load_q <= rd_req_q;
      if (ss_fall) begin
        rd_active_q  <= 1'b1;
        rd_addr_q    <= '0;
        rd_req_q     <= 1'b1;
        rd_first_q   <= 1'b1;
        rd_swap_q    <= 1'b0;
        rd_bit_cnt_q <= '0;
      end else if (ss_rise) begin
        rd_active_q <= 1'b0;
      end else if (rd_active_q) begin
        if (sclk_rise) begin
          rd_bit_cnt_q <= rd_bit_cnt_q + 4'd1;
          if (rd_bit_cnt_q == 4'd15) begin
            rd_addr_q <= rd_addr_q + 8'd1;
            rd_req_q  <= 1'b1;
            rd_swap_q <= 1'b1;
          end
        end
        if (sclk_fall) begin
          if (rd_swap_q) begin
            miso_sr_q <= rd_buf_q;
            rd_swap_q <= 1'b0;
          end else begin
            miso_sr_q <= {miso_sr_q[14:0], 1'b0};
          end
        end
      end
      if (rd_load_q) begin
        if (rd_first_q) begin
          miso_sr_q  <= byte_swap(rd_data);
          rd_first_q <= 1'b0;
        end else begin
          rd_buf_q <= byte_swap(rd_data);
        end
      end
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign spi_miso    = miso_sr_q[15];
  assign spi_miso_oe = ~ss_s;

endmodule

// File: tb/tb_ide_spi_link.sv
// Randomized scoreboard bench for ide_spi_link: an SPI master drives frames,
// a frame-level model predicts writes, and a monitor checks them as they occur.
module tb_ide_spi_link;

  localparam int SW   = 256;
  localparam int CW   = 4;
  localparam int HALF = 4;

  typedef logic [15:0] wq_t[$];
  typedef struct packed {
    logic [8:0]  addr;
    logic [15:0] data;
    logic        done;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_ss_n, spi_sclk, spi_mosi;
  logic        spi_miso, spi_miso_oe;
  logic        wr_valid, rd_req, frame_done, frame_abort;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data = '0;

  int tests = 0;
  int fails = 0;
  int abort_cnt = 0;
  int rd_req_cnt = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  bit  rx_bits[$];

  always #5 clk = ~clk;

  ide_spi_link dut (
    .clk(clk), .reset(reset),
    .spi_ss_n(spi_ss_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_done(frame_done), .frame_abort(frame_abort)
  );

  // Sector RAM stand-in: one-cycle registered read of {addr, ~addr}.
  always @(posedge clk) if (rd_req) rd_data <= {rd_addr, rd_addr ^ 8'hFF};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (frame_abort) abort_cnt++;
      if (rd_req) rd_req_cnt++;
      if (wr_valid) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                   wr_addr, wr_data);
        end else begin
          mon_e = exp_q.pop_front();
          $display("[TB] write addr 0x%0h data 0x%0h done %0b", wr_addr, wr_data, frame_done);
          check("wr_addr", 32'(wr_addr), 32'(mon_e.addr));
          check("wr_data", 32'(wr_data), 32'(mon_e.data));
          check("frame_done", 32'(frame_done), 32'(mon_e.done));
        end
      end else if (frame_done) begin
        check("stray_frame_done", 32'(frame_done), 32'd0);
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input bit b);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    rx_bits.push_back(spi_miso);
    spi_sclk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_sclk = 1'b0;
  endtask

  // Frame-level model: header picks sector and/or command regions, later words
  // are dropped, and a partial word inside a region counts as an abort.
  task automatic run_frame(input logic [7:0] hdr, input wq_t words, input int extra,
                           input string tag);
    bit   tx[$];
    int   cap_sec, cap_cmd, n, nbits, k, ci;
    bit   exp_abort;
    wr_t  e;
    logic [7:0] b, exp_b;

    n       = words.size();
    cap_sec = hdr[7] ? SW : 0;
    cap_cmd = (hdr[7] || hdr[6]) ? CW : 0;
    for (int i = 0; i < n; i++) begin
      if (i < cap_sec) begin
        e.addr = {1'b0, 8'(i)};
        e.data = {words[i][7:0], words[i][15:8]};
        e.done = 1'b0;
        exp_q.push_back(e);
      end else if (i < cap_sec + cap_cmd) begin
        ci     = i - cap_sec;
        e.addr = {1'b1, 8'(ci)};
        e.data = words[i];
        e.done = (ci == cap_cmd - 1);
        exp_q.push_back(e);
      end
    end
    exp_abort = (extra > 0) && (n < cap_sec + cap_cmd);

    for (int i = 7; i >= 0; i--) tx.push_back(hdr[i]);
    foreach (words[i]) for (int j = 15; j >= 0; j--) tx.push_back(words[i][j]);
    for (int i = 0; i < extra; i++) tx.push_back(1'($urandom));
    nbits = tx.size();

    rx_bits.delete();
    rd_req_cnt = 0;
    abort_cnt  = 0;
    spi_ss_n = 1'b0;
    repeat (8) @(negedge clk);
    foreach (tx[i]) send_bit(tx[i]);
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("[TB] frame %s hdr 0x%02h words %0d extra %0d", tag, hdr, n, extra);
    check({tag, "_writes_outstanding"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check({tag, "_abort_count"}, 32'(abort_cnt), 32'(exp_abort));
    check({tag, "_rd_req_count"}, 32'(rd_req_cnt), 32'(1 + nbits / 16));
    for (int j = 0; j < nbits / 8; j++) begin
      b = '0;
      for (int bi = 0; bi < 8; bi++) b = {b[6:0], rx_bits[j*8+bi]};
      k = (j / 2) % 256;
      exp_b = (j % 2 == 0) ? (8'(k) ^ 8'hFF) : 8'(k);
      check({tag, "_miso_byte"}, 32'(b), 32'(exp_b));
    end
  endtask

  initial begin
    wq_t w;
    logic [15:0] w0;

    reset    = 1'b0;
    spi_ss_n = 1'b1;
    spi_sclk = 1'b0;
    spi_mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_frame_abort", 32'(frame_abort), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_miso_oe", 32'(spi_miso_oe), 32'd0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Command write with fixed words.
    w = '{16'h1234, 16'h5678, 16'h9ABC, 16'h0003};
    run_frame(8'h40, w, 0, "cmd");

    // Sector write: 256 words of {n, ~n} then four command words.
    w.delete();
    for (int i = 0; i < SW; i++) w.push_back({8'(i), ~8'(i)});
    for (int i = 0; i < CW; i++) w.push_back(16'($urandom));
    run_frame(8'h80, w, 0, "sector");

    // Read-only stream: 48 clocks with a discard header.
    w = '{16'h0000, 16'h0000};
    run_frame(8'h00, w, 8, "read");

    // Abort: one word, then 9 bits of the next.
    w = '{16'($urandom)};
    run_frame(8'h40, w, 9, "abort");
    w = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(8'h40, w, 0, "after_abort");

    // Discard header plus 64 clocks.
    w = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(8'h00, w, 0, "discard");

    // Randomized non-sector frames.
    for (int r = 0; r < 5; r++) begin
      w.delete();
      for (int i = 0; i < int'($urandom_range(0, 6)); i++) w.push_back(16'($urandom));
      run_frame(8'($urandom_range(0, 127)), w, int'($urandom_range(0, 15)), "random");
    end

    // Reset in the middle of a command word with select held low.
    w0 = 16'($urandom);
    begin
      wr_t e;
      e.addr = 9'h100;
      e.data = w0;
      e.done = 1'b0;
      exp_q.push_back(e);
    end
    abort_cnt = 0;
    spi_ss_n  = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 7; i >= 0; i--) send_bit(i == 6);
    for (int i = 15; i >= 0; i--) send_bit(w0[i]);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_wr_valid", 32'(wr_valid), 32'd0);
    check("midrst_rd_req", 32'(rd_req), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 11 + 32; i++) send_bit(1'($urandom));
    repeat (HALF) @(negedge clk);
    spi_ss_n = 1'b1;
    repeat (10) @(negedge clk);
    $display("[TB] frame midrst hdr 0x40 interrupted by reset");
    check("midrst_writes_outstanding", 32'(exp_q.size()), 32'd0);
    check("midrst_abort_count", 32'(abort_cnt), 32'd0);
    exp_q.delete();
    w = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    run_frame(8'h40, w, 0, "after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
